counter_sweep_ctrl: RTL

Controller that drives the control side of the team's up/down counter (load_n, up_down, ce, data_load) and consumes its status side (count_out, max_count, zero). It produces a triangle sweep lo_bound -> hi_bound -> lo_bound for a programmed number of periods, or continuously. It sits beside the counter as its sequencer, so the counter can be used as a PWM/scan ramp without software stepping it.

---
 rtl/counter_sweep_ctrl.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/counter_sweep_ctrl.sv
// Triangle-sweep sequencer for the up/down counter: lo -> hi -> lo for N periods or continuously.
// Optional turning-point dwell states are built in when SWEEP_DWELL_EN is defined.
module counter_sweep_ctrl #(
   parameter int WIDTH  = 4,
   parameter int PCNT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              continuous,
   input  logic [PCNT_W-1:0] num_periods,
   input  logic [WIDTH-1:0]  lo_bound,
   input  logic [WIDTH-1:0]  hi_bound,
   input  logic [WIDTH-1:0]  dwell,
   input  logic [WIDTH-1:0]  count_in,
   input  logic              max_count,
   input  logic              zero,
   output logic              load_n,
   output logic              up_down,
   output logic              ce,
   output logic [WIDTH-1:0]  data_load,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [PCNT_W-1:0] periods_done
);

`ifdef SWEEP_DWELL_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_UP     = 3'd2,
      S_DOWN   = 3'd3,
      S_PEAK   = 3'd4,
      S_TROUGH = 3'd5
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_UP   = 2'd2,
      S_DOWN = 2'd3
   } state_t;
`endif

   state_t              r_state;
   state_t              w_next_state;
   logic [WIDTH-1:0]    r_lo;
   logic [WIDTH-1:0]    r_hi;
   logic [PCNT_W-1:0]   r_num;
   logic                r_cont;
   logic [PCNT_W-1:0]   r_periods_done;
   logic                r_done;
   logic                r_err;

   logic                w_start_ok;
   logic                w_at_hi;
   logic                w_at_lo;
   logic [PCNT_W:0]     w_pd_inc;
   logic                w_more;
   logic                w_accept;
   logic                w_period_end;
   logic                w_done_nxt;
   logic                w_err_nxt;
   logic                w_ce;
   logic                w_up_down;
   logic                w_load_n;

`ifdef SWEEP_DWELL_EN
   logic [WIDTH-1:0]    r_dwell;
   logic [WIDTH-1:0]    r_dwell_cnt;
   logic                w_dwell_load;
   logic                w_dwell_dec;
`else
   logic                w_dwell_unused;
   assign w_dwell_unused = ^dwell;
`endif

   assign w_start_ok = (lo_bound < hi_bound) && (continuous || (num_periods != {PCNT_W{1'b0}}));
   // max_count/zero act as backstops so a bad bound can never make the counter wrap
   assign w_at_hi    = (count_in == r_hi) || max_count;
   assign w_at_lo    = (count_in == r_lo) || zero;
   assign w_pd_inc   = {1'b0, r_periods_done} + {{PCNT_W{1'b0}}, 1'b1};
   assign w_more     = (w_pd_inc < {1'b0, r_num});

   // Next-state and Mealy counter-control decode
   always_comb begin
      w_next_state = r_state;
      w_ce         = 1'b0;
      w_up_down    = 1'b1;
      w_load_n     = 1'b1;
      w_accept     = 1'b0;
      w_period_end = 1'b0;
      w_done_nxt   = 1'b0;
      w_err_nxt    = 1'b0;
`ifdef SWEEP_DWELL_EN
      w_dwell_load = 1'b0;
      w_dwell_dec  = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (w_start_ok) begin
                  w_accept     = 1'b1;
                  w_next_state = S_LOAD;
               end else begin
                  w_err_nxt    = 1'b1;
               end
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_LOAD: begin
            if (stop) begin
               w_next_state = S_IDLE;
            end else begin
               w_load_n     = 1'b0;
               w_next_state = S_UP;
            end
         end
         S_UP: begin
            if (stop) begin
               w_next_state = S_IDLE;
            end else if (w_at_hi) begin
`ifdef SWEEP_DWELL_EN
               if (r_dwell != {WIDTH{1'b0}}) begin
                  w_dwell_load = 1'b1;
                  w_next_state = S_PEAK;
               end else begin
                  w_ce         = 1'b1;
                  w_up_down    = 1'b0;
                  w_next_state = S_DOWN;
               end
`else
               w_ce         = 1'b1;
               w_up_down    = 1'b0;
               w_next_state = S_DOWN;
`endif
            end else begin
               w_ce      = 1'b1;
               w_up_down = 1'b1;
            end
         end
         S_DOWN: begin
            if (stop) begin
               w_next_state = S_IDLE;
            end else if (w_at_lo) begin
               w_period_end = 1'b1;
               if (r_cont || w_more) begin
`ifdef SWEEP_DWELL_EN
                  if (r_dwell != {WIDTH{1'b0}}) begin
                     w_dwell_load = 1'b1;
                     w_next_state = S_TROUGH;
                  end else begin
                     w_ce         = 1'b1;
                     w_up_down    = 1'b1;
                     w_next_state = S_UP;
                  end
`else
                  w_ce         = 1'b1;
                  w_up_down    = 1'b1;
                  w_next_state = S_UP;
`endif
               end else begin
                  w_done_nxt   = 1'b1;
                  w_next_state = S_IDLE;
               end
            end else begin
               w_ce      = 1'b1;
               w_up_down = 1'b0;
            end
         end
`ifdef SWEEP_DWELL_EN
         S_PEAK: begin
            if (stop) begin
               w_next_state = S_IDLE;
            end else if (r_dwell_cnt == {WIDTH{1'b0}}) begin
               w_ce         = 1'b1;
               w_up_down    = 1'b0;
               w_next_state = S_DOWN;
            end else begin
               w_dwell_dec  = 1'b1;
            end
         end
         S_TROUGH: begin
            if (stop) begin
               w_next_state = S_IDLE;
            end else if (r_dwell_cnt == {WIDTH{1'b0}}) begin
               w_ce         = 1'b1;
               w_up_down    = 1'b1;
               w_next_state = S_UP;
            end else begin
               w_dwell_dec  = 1'b1;
            end
         end
`endif
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // State, run configuration and status registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_lo           <= {WIDTH{1'b0}};
         r_hi           <= {WIDTH{1'b0}};
         r_num          <= {PCNT_W{1'b0}};
         r_cont         <= 1'b0;
         r_periods_done <= {PCNT_W{1'b0}};
         r_done         <= 1'b0;
         r_err          <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
         if (w_accept) begin
            r_lo           <= lo_bound;
            r_hi           <= hi_bound;
            r_num          <= num_periods;
            r_cont         <= continuous;
            r_periods_done <= {PCNT_W{1'b0}};
         end else if (w_period_end && (r_periods_done != {PCNT_W{1'b1}})) begin
            r_periods_done <= w_pd_inc[PCNT_W-1:0];
         end else begin
            r_periods_done <= r_periods_done;
         end
      end
   end

`ifdef SWEEP_DWELL_EN
   // Dwell length latch and remaining-hold counter; the turning cycle itself is the first hold cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_dwell     <= {WIDTH{1'b0}};
         r_dwell_cnt <= {WIDTH{1'b0}};
      end else begin
         if (w_accept) begin
            r_dwell <= dwell;
         end
         if (w_dwell_load) begin
            r_dwell_cnt <= r_dwell - {{(WIDTH-1){1'b0}}, 1'b1};
         end else if (w_dwell_dec) begin
            r_dwell_cnt <= r_dwell_cnt - {{(WIDTH-1){1'b0}}, 1'b1};
         end
      end
   end
`endif

   assign load_n       = w_load_n;
   assign up_down      = w_up_down;
   assign ce           = w_ce;
   assign data_load    = r_lo;
   assign busy         = (r_state != S_IDLE);
   assign done         = r_done;
   assign err          = r_err;
   assign periods_done = r_periods_done;

endmodule
